// File: rtl/ov7725_cfg_sequencer.sv
// ov7725_cfg_sequencer
// Walks the OV7725 init table (entries 0..TABLE_SIZE-1) and issues one SCCB
// write per entry to the SCCB master. Inserts the power-up settle delay
// before the first fetch and the soft-reset settle delay after an ACKed
// write of reg 0x12 with bit7 set. A NACKed write is re-issued up to
// MAX_RETRY times before the run stops in ERROR.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start            one-cycle pulse; starts a run (ignored while busy)
//   tbl_addr         registered table address to the init ROM
//   tbl_data         ROM word {reg, value}, valid one clk after tbl_addr
//   cmd_valid/ready  write request handshake to the SCCB master
//   cmd_dev/reg/data slave address (constant), sub-address, value
//   cmd_done/nack    transaction finished pulse; nack qualified by done
//   busy/done/error  run status; done and error are sticky
//   err_addr         table index that ran out of retries
//   dbg_state        current FSM state, for checkers and debug
//
// Handshake: cmd_valid is high only in ISSUE. A write is transferred on the
// rising clk edge where cmd_valid & cmd_ready; until then cmd_reg/cmd_data
// are held stable, and cmd_valid drops on the cycle after the transfer.
// cmd_ready is ignored outside ISSUE and cmd_done outside WAIT_ACK.
module ov7725_cfg_sequencer #(
  parameter int unsigned TABLE_SIZE   = 68,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter logic [7:0]  DEV_ADDR     = 8'h42,
  parameter logic [19:0] POWERUP_WAIT = 20'd1_000_000,
  parameter logic [19:0] RESET_WAIT   = 20'd500_000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] tbl_addr,
  input  logic [15:0]           tbl_data,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [7:0]            cmd_dev,
  output logic [7:0]            cmd_reg,
  output logic [7:0]            cmd_data,
  input  logic                  cmd_done,
  input  logic                  cmd_nack,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [3:0]            dbg_state
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    PWR_WAIT = 4'd1,
    FETCH    = 4'd2,
    LATCH    = 4'd3,
    ISSUE    = 4'd4,
    WAIT_ACK = 4'd5,
    POST     = 4'd6,
    NEXT     = 4'd7,
    DONE     = 4'd8,
    ERROR    = 4'd9
  } state_t;

  // PWR_WAIT lasts POWERUP_WAIT cycles; a zero wait still spends one cycle.
  localparam logic [19:0] PWR_LIM = (POWERUP_WAIT == 20'd0) ? 20'd0 : POWERUP_WAIT - 20'd1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TABLE_SIZE - 1);
  localparam logic [1:0] RETRY_LIM = 2'(MAX_RETRY);

  state_t                state_q, state_d;
  logic [19:0]           cnt_q, cnt_d;
  logic [1:0]            retry_q, retry_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            reg_q, reg_d;
  logic [7:0]            data_q, data_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  logic        soft_rst;
  logic [19:0] post_lim;

  // A write of COM7 (0x12) with bit7 set resets the sensor, which then needs
  // RESET_WAIT cycles before it accepts the next write. POST always spends
  // its own first cycle, then counts the RESET_WAIT settle cycles on top.
  assign soft_rst = (reg_q == 8'h12) && data_q[7];
  assign post_lim = soft_rst ? RESET_WAIT : 20'd0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    addr_d     = addr_q;
    reg_d      = reg_q;
    data_d     = data_q;
    done_d     = done_q;
    error_d    = error_q;
    err_addr_d = err_addr_q;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d    = PWR_WAIT;
          cnt_d      = 20'd0;
          addr_d     = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_addr_d = '0;
        end
      end
      PWR_WAIT: begin
        if (cnt_q >= PWR_LIM) begin
          state_d = FETCH;
          cnt_d   = 20'd0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      // The ROM registers tbl_addr during FETCH; its word is valid in LATCH.
      FETCH: state_d = LATCH;
      LATCH: begin
        reg_d   = tbl_data[15:8];
        data_d  = tbl_data[7:0];
        retry_d = 2'd0;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (cmd_ready) state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (cmd_done) begin
          if (!cmd_nack) begin
            state_d = POST;
            cnt_d   = 20'd0;
          end else if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + 2'd1;
            state_d = ISSUE;
          end else begin
            state_d    = ERROR;
            error_d    = 1'b1;
            err_addr_d = addr_q;
          end
        end
      end
      POST: begin
        if (cnt_q >= post_lim) begin
          state_d = NEXT;
          cnt_d   = 20'd0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      NEXT: begin
        if (addr_q == LAST_ADDR) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 20'd0;
      retry_q    <= 2'd0;
      addr_q     <= '0;
      reg_q      <= 8'd0;
      data_q     <= 8'd0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      addr_q     <= addr_d;
      reg_q      <= reg_d;
      data_q     <= data_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign tbl_addr  = addr_q;
  assign cmd_valid = (state_q == ISSUE);
  assign cmd_dev   = DEV_ADDR;
  assign cmd_reg   = reg_q;
  assign cmd_data  = data_q;
  assign busy      = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);
  assign done      = done_q;
  assign error     = error_q;
  assign err_addr  = err_addr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ov7725_cfg_sequencer.sv
// Bench for ov7725_cfg_sequencer: init ROM model, SCCB master model with
// configurable stall/NACK behaviour, and an expected-write queue.
module tb_ov7725_cfg_sequencer;
  localparam int TABLE_SIZE = 68;
  localparam int PWR_W = 10;
  localparam int RST_W = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  tbl_addr;
  logic [15:0] tbl_data = 16'h0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [7:0]  cmd_dev, cmd_reg, cmd_data;
  logic        cmd_done = 1'b0;
  logic        cmd_nack = 1'b0;
  logic        busy, done, error;
  logic [7:0]  err_addr;
  logic [3:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_log[$];
  logic [15:0] rom [0:255];

  int cyc = 0;
  int done_wait = 0;
  int entry_idx = 0;
  int done_edge = 0;
  int stall_idx = -1;
  int stall_left = 0;
  int stall_seen = 0;
  int nack_idx = -1;
  int nack_left = 0;
  int lat [0:TABLE_SIZE-1];
  logic prev_valid = 1'b0;

  ov7725_cfg_sequencer #(
    .TABLE_SIZE(TABLE_SIZE), .ADDR_WIDTH(8), .DEV_ADDR(8'h42),
    .POWERUP_WAIT(20'(PWR_W)), .RESET_WAIT(20'(RST_W)), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .cmd_done(cmd_done), .cmd_nack(cmd_nack),
    .busy(busy), .done(done), .error(error), .err_addr(err_addr),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / ROM ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      rom[i] = {8'h20 + b, b ^ 8'h5a};
    end
    rom[0]  = 16'h1280;
    rom[1]  = 16'h3d03;
    rom[3]  = 16'h1723;
    rom[5]  = 16'h1907;
    rom[12] = 16'h1203;
    rom[67] = 16'h0e65;
    for (int i = 0; i < TABLE_SIZE; i++) lat[i] = -1;
  end

  // ---------------- SCCB master model + scoreboard pop ----------------
  // Runs on the falling edge: decides cmd_ready/cmd_done for the next rising
  // edge and checks each write as it is accepted.
  always @(negedge clk) begin
    logic [15:0] exp_w;
    if (!rst_n) begin
      cmd_ready = 1'b0; cmd_done = 1'b0; cmd_nack = 1'b0;
      done_wait = 0; entry_idx = 0; prev_valid = 1'b0;
    end else begin
      cmd_done = 1'b0;
      cmd_nack = 1'b0;
      if (cmd_valid && !prev_valid && entry_idx < TABLE_SIZE) lat[entry_idx] = cyc - done_edge;
      prev_valid = cmd_valid;
      if (cmd_ready) begin
        cmd_ready = 1'b0;
        done_wait = 2;
      end else if (done_wait > 0) begin
        done_wait--;
        if (done_wait == 0) begin
          cmd_done  = 1'b1;
          done_edge = cyc + 1;
          if (entry_idx == nack_idx && nack_left > 0) begin
            cmd_nack = 1'b1;
            nack_left--;
          end else begin
            entry_idx++;
          end
        end
      end else if (cmd_valid) begin
        if (entry_idx == stall_idx && stall_left > 0) begin
          stall_left--;
          stall_seen++;
          checks++;
          if (exp_q.size() == 0 || {cmd_reg, cmd_data} !== exp_q[0]) begin
            errors++;
            $display("FAIL hold_stable: got %h expected %h", {cmd_reg, cmd_data},
                     (exp_q.size() == 0) ? 16'hxxxx : exp_q[0]);
          end
        end else begin
          cmd_ready = 1'b1;
          obs_log.push_back({cmd_reg, cmd_data});
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got %h expected none", {cmd_reg, cmd_data});
          end else begin
            exp_w = exp_q.pop_front();
            if ({cmd_dev, cmd_reg, cmd_data} !== {8'h42, exp_w}) begin
              errors++;
              $display("FAIL write: got %h expected %h", {cmd_dev, cmd_reg, cmd_data}, {8'h42, exp_w});
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic raw_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_start();
    entry_idx = 0;
    done_edge = cyc + 1;
    raw_start();
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(rom[i]);
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!(done || error) && n < 20000) begin
      step(1);
      n++;
    end
    checks++;
    if (!(done || error)) begin
      errors++;
      $display("FAIL %s_timeout: got done=%b error=%b expected an end state", name, done, error);
    end
  endtask

  task automatic check_end(input string name, input logic e_done, input logic e_err, input logic [7:0] e_addr);
    checks++;
    if ({done, error, busy, err_addr} !== {e_done, e_err, 1'b0, e_addr}) begin
      errors++;
      $display("FAIL %s_status: got done=%b error=%b busy=%b err_addr=%0d expected %b %b 0 %0d",
               name, done, error, busy, err_addr, e_done, e_err, e_addr);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes: got %0d left expected 0", name, exp_q.size());
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({tbl_addr, cmd_valid, cmd_reg, cmd_data, busy, done, error, err_addr, dbg_state} !== '0
        || cmd_dev !== 8'h42) begin
      errors++;
      $display("FAIL %s: got addr=%h v=%b reg=%h data=%h busy=%b done=%b err=%b ea=%h st=%h dev=%h expected zeros dev=42",
               name, tbl_addr, cmd_valid, cmd_reg, cmd_data, busy, done, error, err_addr, dbg_state, cmd_dev);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    step(3);
    check_outputs_zero("reset_values");
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_nominal();
    obs_log.delete();
    push_range(0, TABLE_SIZE - 1);
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL nominal_busy: got %b expected 1", busy);
    end
    wait_end("nominal");
    step(1);
    check_end("nominal", 1'b1, 1'b0, 8'd0);
    checks++;
    if (obs_log.size() != TABLE_SIZE) begin
      errors++;
      $display("FAIL nominal_count: got %0d expected %0d", obs_log.size(), TABLE_SIZE);
    end else begin
      checks++;
      if (obs_log[0] !== 16'h1280 || obs_log[1] !== 16'h3d03 || obs_log[TABLE_SIZE-1] !== 16'h0e65) begin
        errors++;
        $display("FAIL nominal_order: got %h %h %h expected 1280 3d03 0e65",
                 obs_log[0], obs_log[1], obs_log[TABLE_SIZE-1]);
      end
    end
    checks++;
    if (lat[0] != PWR_W + 2) begin
      errors++;
      $display("FAIL powerup_latency: got %0d expected %0d", lat[0], PWR_W + 2);
    end
    checks++;
    if (lat[1] != RST_W + 4) begin
      errors++;
      $display("FAIL soft_reset_delay: got %0d expected %0d", lat[1], RST_W + 4);
    end
    checks++;
    if (lat[2] != 4 || lat[13] != 4) begin
      errors++;
      $display("FAIL plain_delay: got %0d/%0d expected 4/4", lat[2], lat[13]);
    end
  endtask

  task automatic test_backpressure();
    stall_idx = 5;
    stall_left = 7;
    stall_seen = 0;
    push_range(0, TABLE_SIZE - 1);
    pulse_start();
    wait_end("backpressure");
    check_end("backpressure", 1'b1, 1'b0, 8'd0);
    checks++;
    if (stall_seen != 7) begin
      errors++;
      $display("FAIL backpressure_hold: got %0d held cycles expected 7", stall_seen);
    end
    stall_idx = -1;
  endtask

  task automatic test_nack_retry();
    nack_idx = 3;
    nack_left = 2;
    push_range(0, 3);
    push_range(3, 3);
    push_range(3, TABLE_SIZE - 1);
    pulse_start();
    wait_end("nack_retry");
    check_end("nack_retry", 1'b1, 1'b0, 8'd0);
    nack_idx = -1;
  endtask

  task automatic test_nack_error();
    int seen_valid;
    nack_idx = 3;
    nack_left = 4;
    push_range(0, 3);
    for (int i = 0; i < 3; i++) push_range(3, 3);
    pulse_start();
    wait_end("nack_error");
    check_end("nack_error", 1'b0, 1'b1, 8'd3);
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (cmd_valid) seen_valid++;
    end
    checks++;
    if (seen_valid != 0) begin
      errors++;
      $display("FAIL error_quiet: got %0d valid cycles expected 0", seen_valid);
    end
    nack_idx = -1;
  endtask

  task automatic test_restart_after_error();
    push_range(0, TABLE_SIZE - 1);
    pulse_start();
    checks++;
    if ({error, err_addr, busy} !== {1'b0, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL restart_clear: got error=%b err_addr=%0d busy=%b expected 0 0 1", error, err_addr, busy);
    end
    wait_end("restart_error");
    check_end("restart_error", 1'b1, 1'b0, 8'd0);
  endtask

  task automatic test_start_ignored();
    push_range(0, TABLE_SIZE - 1);
    pulse_start();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL restart_done_clear: got %b expected 0", done);
    end
    step(4);
    raw_start();
    step(200);
    raw_start();
    wait_end("start_ignored");
    check_end("start_ignored", 1'b1, 1'b0, 8'd0);
  endtask

  task automatic test_reset_midrun();
    int n;
    stall_idx = 40;
    stall_left = 100000;
    push_range(0, TABLE_SIZE - 1);
    pulse_start();
    n = 0;
    while (!(cmd_valid && entry_idx == 40) && n < 5000) begin
      step(1);
      n++;
    end
    checks++;
    if (!(cmd_valid && entry_idx == 40)) begin
      errors++;
      $display("FAIL midrun_reach: got valid=%b entry=%0d expected 1 40", cmd_valid, entry_idx);
    end
    rst_n = 1'b0;
    step(1);
    check_outputs_zero("midrun_reset");
    rst_n = 1'b1;
    exp_q.delete();
    stall_idx = -1;
    stall_left = 0;
    step(3);
    checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_idle: got valid=%b busy=%b expected 0 0", cmd_valid, busy);
    end
    push_range(0, TABLE_SIZE - 1);
    pulse_start();
    wait_end("midrun_rerun");
    check_end("midrun_rerun", 1'b1, 1'b0, 8'd0);
    checks++;
    if (lat[0] != PWR_W + 2) begin
      errors++;
      $display("FAIL rerun_powerup: got %0d expected %0d", lat[0], PWR_W + 2);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_nack_retry();
    test_nack_error();
    test_restart_after_error();
    test_start_ignored();
    test_reset_midrun();
    step(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
